// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Bus bundle for the multi-port register file: two read ports,
//               two write ports, the issue (destination claim) port and the
//               busy counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              read_busy1;
    logic              read_busy2;
    logic              write_enable0;
    logic [ADDR_W-1:0] write_addr0;
    logic [DATA_W-1:0] write_data0;
    logic              write_enable1;
    logic [ADDR_W-1:0] write_addr1;
    logic [DATA_W-1:0] write_data1;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W:0]   busy_count;

    // Datapath / decode side: drives addresses, writes and claims
    modport master (
        output read_addr1, read_addr2,
        output write_enable0, write_addr0, write_data0,
        output write_enable1, write_addr1, write_data1,
        output issue_valid, issue_addr,
        input  read_data1, read_data2, read_busy1, read_busy2, busy_count
    );

    // Register file side
    modport slave (
        input  read_addr1, read_addr2,
        input  write_enable0, write_addr0, write_data0,
        input  write_enable1, write_addr1, write_data1,
        input  issue_valid, issue_addr,
        output read_data1, read_data2, read_busy1, read_busy2, busy_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised register file with two asynchronous read ports,
//               two synchronous write ports (W0 ALU, W1 memory), optional
//               same-cycle write-to-read bypass, optional hardwired zero
//               register and a per-register busy scoreboard with a
//               registered busy population count.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  wire          clk,
    input  wire          rst,
    regfile_mp_if.slave  bus
);
    localparam int c_nregs = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_regs [c_nregs];
    logic [c_nregs-1:0] r_busy;
    logic [ADDR_W:0]    r_busy_count;

    logic               w_we0;
    logic               w_we1;
    logic               w_issue;
    logic [c_nregs-1:0] w_busy_next;
    logic [ADDR_W:0]    w_busy_pop;
    logic [ADDR_W-1:0]  w_raddr [2];
    logic [DATA_W-1:0]  w_rdata [2];
    logic               w_rbusy [2];

    // Qualified enables: with a hardwired zero register, accesses to
    // address 0 are dropped here so nothing downstream has to care.
    always_comb begin
        w_we0   = bus.write_enable0;
        w_we1   = bus.write_enable1;
        w_issue = bus.issue_valid;
        if (ZERO_REG != 0) begin
            if (bus.write_addr0 == '0) w_we0   = 1'b0;
            if (bus.write_addr1 == '0) w_we1   = 1'b0;
            if (bus.issue_addr  == '0) w_issue = 1'b0;
        end
    end

    // Next busy vector: writes retire producers, an issue claims one; the
    // claim is applied last so a same-cycle claim beats a retiring write.
    always_comb begin
        w_busy_next = r_busy;
        if (w_we0)   w_busy_next[bus.write_addr0] = 1'b0;
        if (w_we1)   w_busy_next[bus.write_addr1] = 1'b0;
        if (w_issue) w_busy_next[bus.issue_addr]  = 1'b1;
    end

    // Population count of the next busy vector, registered below
    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < c_nregs; i++) begin
            w_busy_pop = w_busy_pop + {{ADDR_W{1'b0}}, w_busy_next[i]};
        end
    end

    // Storage and scoreboard update; W1 is written last so it wins on a
    // same-address collision with W0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_nregs; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_we0) r_regs[bus.write_addr0] <= bus.write_data0;
            if (w_we1) r_regs[bus.write_addr1] <= bus.write_data1;
            r_busy       <= w_busy_next;
            r_busy_count <= w_busy_pop;
        end
    end

    assign w_raddr[0] = bus.read_addr1;
    assign w_raddr[1] = bus.read_addr2;

    // Read muxes: optional bypass (W1 over W0 over storage), then the zero
    // register override on top of everything.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_rdata[k] = r_regs[w_raddr[k]];
            w_rbusy[k] = r_busy[w_raddr[k]];
            if (BYPASS != 0) begin
                if (w_we1 && (bus.write_addr1 == w_raddr[k])) begin
                    w_rdata[k] = bus.write_data1;
                    w_rbusy[k] = 1'b0;
                end else if (w_we0 && (bus.write_addr0 == w_raddr[k])) begin
                    w_rdata[k] = bus.write_data0;
                    w_rbusy[k] = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (w_raddr[k] == '0)) begin
                w_rdata[k] = '0;
                w_rbusy[k] = 1'b0;
            end
        end
    end

    assign bus.read_data1 = w_rdata[0];
    assign bus.read_data2 = w_rdata[1];
    assign bus.read_busy1 = w_rbusy[0];
    assign bus.read_busy2 = w_rbusy[1];
    assign bus.busy_count = r_busy_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances share one
//               stimulus stream: instance 0 uses BYPASS=1/ZERO_REG=0,
//               instance 1 uses BYPASS=0/ZERO_REG=1. A reference model
//               pushes expected values to a scoreboard queue as stimulus is
//               driven; they are popped and compared when outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    localparam int c_dw = 16;
    localparam int c_aw = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(c_dw), .ADDR_W(c_aw)) bus0 ();
    regfile_mp_if #(.DATA_W(c_dw), .ADDR_W(c_aw)) bus1 ();

    regfile_mp #(.DATA_W(c_dw), .ADDR_W(c_aw), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    regfile_mp #(.DATA_W(c_dw), .ADDR_W(c_aw), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Reference model state per configuration
    int          m_bypass [2] = '{1, 0};
    int          m_zreg   [2] = '{0, 1};
    logic [15:0] m_regs   [2][8];
    logic [7:0]  m_busy   [2];
    logic [3:0]  m_cnt    [2];

    typedef struct {
        string       tag;
        int          cfg;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Current stimulus (mirrored onto both interfaces)
    logic        s_we0, s_we1, s_iv;
    logic [2:0]  s_a0, s_a1, s_ia, s_ra1, s_ra2;
    logic [15:0] s_d0, s_d1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int cfg, input int sel);
        logic [31:0] v;
        v = '0;
        if (cfg == 0) begin
            case (sel)
                0: v = {16'h0, bus0.read_data1};
                1: v = {16'h0, bus0.read_data2};
                2: v = {31'h0, bus0.read_busy1};
                3: v = {31'h0, bus0.read_busy2};
                default: v = {28'h0, bus0.busy_count};
            endcase
        end else begin
            case (sel)
                0: v = {16'h0, bus1.read_data1};
                1: v = {16'h0, bus1.read_data2};
                2: v = {31'h0, bus1.read_busy1};
                3: v = {31'h0, bus1.read_busy2};
                default: v = {28'h0, bus1.busy_count};
            endcase
        end
        return v;
    endfunction

    // Expected combinational read result for one port of one configuration
    function automatic void model_read(input int cfg, input logic [2:0] ra,
                                       output logic [15:0] d, output logic b);
        logic v0, v1;
        v0 = s_we0 && !(m_zreg[cfg] != 0 && s_a0 == 3'd0);
        v1 = s_we1 && !(m_zreg[cfg] != 0 && s_a1 == 3'd0);
        d = m_regs[cfg][ra];
        b = m_busy[cfg][ra];
        if (m_bypass[cfg] != 0) begin
            if (v1 && s_a1 == ra) begin
                d = s_d1; b = 1'b0;
            end else if (v0 && s_a0 == ra) begin
                d = s_d0; b = 1'b0;
            end
        end
        if (m_zreg[cfg] != 0 && ra == 3'd0) begin
            d = 16'h0; b = 1'b0;
        end
    endfunction

    // Apply one rising edge to the model
    function automatic void model_edge(input int cfg, input logic r);
        logic v0, v1, vi;
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[cfg][i] = 16'h0;
            m_busy[cfg] = 8'h0;
            m_cnt[cfg]  = 4'd0;
            return;
        end
        v0 = s_we0 && !(m_zreg[cfg] != 0 && s_a0 == 3'd0);
        v1 = s_we1 && !(m_zreg[cfg] != 0 && s_a1 == 3'd0);
        vi = s_iv  && !(m_zreg[cfg] != 0 && s_ia == 3'd0);
        if (v0) begin m_regs[cfg][s_a0] = s_d0; m_busy[cfg][s_a0] = 1'b0; end
        if (v1) begin m_regs[cfg][s_a1] = s_d1; m_busy[cfg][s_a1] = 1'b0; end
        if (vi) m_busy[cfg][s_ia] = 1'b1;
        m_cnt[cfg] = 4'($countones(m_busy[cfg]));
    endfunction

    task automatic push_exp(input int cfg, input int sel, input string name, input logic [31:0] e);
        exp_t x;
        x.tag = $sformatf("cfg%0d %s", cfg, name);
        x.cfg = cfg;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            check(x.tag, observe(x.cfg, x.sel), x.exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check reads mid-cycle,
    // clock the edge, then check the registered busy count.
    task automatic step(input logic r,
                        input logic we0, input logic [2:0] a0, input logic [15:0] d0,
                        input logic we1, input logic [2:0] a1, input logic [15:0] d1,
                        input logic iv,  input logic [2:0] ia,
                        input logic [2:0] ra1, input logic [2:0] ra2);
        logic [15:0] d;
        logic        b;
        @(negedge clk);
        s_we0 = we0; s_a0 = a0; s_d0 = d0;
        s_we1 = we1; s_a1 = a1; s_d1 = d1;
        s_iv = iv; s_ia = ia; s_ra1 = ra1; s_ra2 = ra2;
        rst = r;
        bus0.write_enable0 = we0; bus0.write_addr0 = a0; bus0.write_data0 = d0;
        bus0.write_enable1 = we1; bus0.write_addr1 = a1; bus0.write_data1 = d1;
        bus0.issue_valid = iv; bus0.issue_addr = ia;
        bus0.read_addr1 = ra1; bus0.read_addr2 = ra2;
        bus1.write_enable0 = we0; bus1.write_addr0 = a0; bus1.write_data0 = d0;
        bus1.write_enable1 = we1; bus1.write_addr1 = a1; bus1.write_data1 = d1;
        bus1.issue_valid = iv; bus1.issue_addr = ia;
        bus1.read_addr1 = ra1; bus1.read_addr2 = ra2;
        for (int c = 0; c < 2; c++) begin
            model_read(c, ra1, d, b);
            push_exp(c, 0, $sformatf("read_data1@%0d", ra1), {16'h0, d});
            push_exp(c, 2, $sformatf("read_busy1@%0d", ra1), {31'h0, b});
            model_read(c, ra2, d, b);
            push_exp(c, 1, $sformatf("read_data2@%0d", ra2), {16'h0, d});
            push_exp(c, 3, $sformatf("read_busy2@%0d", ra2), {31'h0, b});
        end
        #1;
        drain();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            model_edge(c, r);
            push_exp(c, 4, "busy_count", {28'h0, m_cnt[c]});
        end
        #1;
        drain();
    endtask

    task automatic idle(input logic [2:0] ra1, input logic [2:0] ra2);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, ra1, ra2);
    endtask

    initial begin
        s_we0 = 1'b0; s_we1 = 1'b0; s_iv = 1'b0;
        s_a0 = '0; s_a1 = '0; s_ia = '0; s_ra1 = '0; s_ra2 = '0;
        s_d0 = '0; s_d1 = '0;
        bus0.write_enable0 = 1'b0; bus0.write_addr0 = '0; bus0.write_data0 = '0;
        bus0.write_enable1 = 1'b0; bus0.write_addr1 = '0; bus0.write_data1 = '0;
        bus0.issue_valid = 1'b0; bus0.issue_addr = '0;
        bus0.read_addr1 = '0; bus0.read_addr2 = '0;
        bus1.write_enable0 = 1'b0; bus1.write_addr0 = '0; bus1.write_data0 = '0;
        bus1.write_enable1 = 1'b0; bus1.write_addr1 = '0; bus1.write_data1 = '0;
        bus1.issue_valid = 1'b0; bus1.issue_addr = '0;
        bus1.read_addr1 = '0; bus1.read_addr2 = '0;
        for (int c = 0; c < 2; c++) model_edge(c, 1'b1);

        // Initial reset: DUT state is unknown until the first reset edge
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state: every address reads 0, not busy, count 0
        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

        // W0 write then read, bypass visible only on instance 0
        step(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd0);
        idle(3'd3, 3'd3);

        // Same-address collision: W1 wins
        step(1'b0, 1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd4);
        idle(3'd5, 3'd5);
        // Different addresses both commit
        step(1'b0, 1'b1, 3'd2, 16'h0002, 1'b1, 3'd6, 16'h0006, 1'b0, 3'd0, 3'd2, 3'd6);
        idle(3'd2, 3'd6);

        // Scoreboard: claim, retire, claim+write same cycle
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd1);
        idle(3'd4, 3'd4);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h00FF, 1'b0, 3'd0, 3'd4, 3'd3);
        idle(3'd4, 3'd1);
        step(1'b0, 1'b1, 3'd4, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd4, 3'd2);
        idle(3'd4, 3'd4);

        // Address 0: ignored on the zero-register instance
        step(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd4);
        idle(3'd0, 3'd0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hC0DE, 1'b0, 3'd0, 3'd0, 3'd5);
        idle(3'd0, 3'd5);

        // Claims over three cycles, then reset overrides a simultaneous write
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 3'd2);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd1, 3'd2);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 3'd6);
        step(1'b1, 1'b1, 3'd1, 16'h7777, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd2, 3'd3);
        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for the processor datapath, the next generation of the 8x16 single-write register file.
- Provides two asynchronous read ports and two synchronous write ports: W0 for ALU writeback, W1 for memory writeback.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, used by decode to detect RAW hazards on in-flight destinations.

Parameters:
DATA_W, 16, width of each register in bits
ADDR_W, 3, address width; depth NREGS = 2**ADDR_W
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, is never busy

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
read_addr1  input  ADDR_W  read port 1 address
read_addr2  input  ADDR_W  read port 2 address
read_data1  output  DATA_W  read port 1 data (combinational)
read_data2  output  DATA_W  read port 2 data (combinational)
read_busy1  output  1  busy bit of read_addr1 (combinational)
read_busy2  output  1  busy bit of read_addr2 (combinational)
write_enable0  input  1  write port 0 enable
write_addr0  input  ADDR_W  write port 0 address
write_data0  input  DATA_W  write port 0 data
write_enable1  input  1  write port 1 enable
write_addr1  input  ADDR_W  write port 1 address
write_data1  input  DATA_W  write port 1 data
issue_valid  input  1  instruction issued with a destination register
issue_addr  input  ADDR_W  destination being claimed
busy_count  output  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Storage: NREGS x DATA_W registers plus NREGS busy bits.
- Reset (rst=1 at rising edge): all registers 0, all busy bits 0, busy_count 0.
  - Reset overrides every write and issue in the same cycle.
  - Reset mid-operation discards all in-flight claims.
  - Read outputs reflect 0 from the cycle after reset.
- Writes: on a rising edge with write_enableN=1, registers[write_addrN] <= write_dataN.
  - If both ports are enabled with equal addresses, port 1 wins; port 0 data is dropped.
  - Writes with different addresses both commit in the same cycle.
- Read, BYPASS=0: read_dataK = registers[read_addrK]. A new value is visible in the cycle after the write edge.
- Read, BYPASS=1, priority:
  1. write port 1 if write_enable1 and write_addr1==read_addrK;
  2. else write port 0 if write_enable0 and write_addr0==read_addrK;
  3. else the stored value.
  This gives 0-cycle write-to-read latency.
- ZERO_REG=1:
  - read_dataK=0 and read_busyK=0 whenever read_addrK==0, overriding bypass.
  - Writes and issues to address 0 are ignored.
- Scoreboard, per rising edge:
  - A write on either port to address A clears busy[A].
  - issue_valid sets busy[issue_addr].
  - If issue_addr equals a write address in the same cycle, set wins: a new producer was claimed.
  - Issue to an already-busy register keeps it busy; no error and no nesting count.
- read_busyK:
  - BYPASS=0: busy[read_addrK].
  - BYPASS=1: 0 if a same-cycle write to read_addrK is occurring, else busy[read_addrK].
  - The issue port does not affect read_busyK combinationally.
- busy_count: registered population count of the busy bits after the edge's update. Range 0..NREGS, hence ADDR_W+1 bits.
- No X on outputs after the first reset. Out-of-range addresses are impossible by width.

Test Plan:
- Reset then read all 8 addresses -> read_data1/2 = 0, read_busy = 0, busy_count = 0.
- Write W0 addr3=0x1234, next cycle read_addr1=3 -> read_data1=0x1234. With BYPASS=1, read_data1=0x1234 in the write cycle itself; with BYPASS=0, the old value 0.
- Same cycle W0 addr5=0xAAAA and W1 addr5=0x5555 -> registers[5]=0x5555. Then W0 addr2=0x0002 and W1 addr6=0x0006 in one cycle -> both stored.
- issue_valid addr4 -> read_busy(4)=1, busy_count=1. W1 writes addr4=0x00FF -> busy clears, count 0. Issue addr4 and write addr4 in the same cycle -> busy stays 1, data updated.
- ZERO_REG=1: write addr0=0xFFFF and issue addr0 -> read addr0 returns 0, busy 0, busy_count unchanged.
- Issue addrs 1, 2, 3 over 3 cycles, then assert rst with a simultaneous W0 addr1=0x7777 -> all registers 0, busy_count 0, registers[1]=0.
